// File: rtl/hot_cold_pkg.sv
// -----------------------------------------------------------------------------
// hot_cold_pkg
// Shared types and constants for the hot-and-cold guessing game sequencer.
//   state_t      : controller states
//   bcd_t        : one BCD digit / key code
//   dist_t       : absolute distance between two-digit values (0..99)
//   KEY_CLEAR    : key code that clears the guess being entered
//   ATTEMPTS_MAX : saturation value of the attempts counter
//   is_digit()   : true for key codes 0..9
// -----------------------------------------------------------------------------
package hot_cold_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTER_T = 3'd1,
    ENTER_O = 3'd2,
    EVAL    = 3'd3,
    RESULT  = 3'd4,
    WIN     = 3'd5,
    LOSE    = 3'd6
  } state_t;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] dist_t;

  localparam bcd_t       KEY_CLEAR    = 4'hC;
  localparam logic [3:0] ATTEMPTS_MAX = 4'd15;

  function automatic logic is_digit(input bcd_t k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/hot_cold_game_ctrl_bcd_dist.sv
// -----------------------------------------------------------------------------
// bcd_dist
// Combinational absolute distance between two two-digit BCD numbers.
// Ports:
//   a_tens_i, a_ones_i : first number (BCD digits)
//   b_tens_i, b_ones_i : second number (BCD digits)
//   dist_o             : |a - b|, 0..99
// -----------------------------------------------------------------------------
module bcd_dist
  import hot_cold_pkg::*;
(
  input  bcd_t  a_tens_i,
  input  bcd_t  a_ones_i,
  input  bcd_t  b_tens_i,
  input  bcd_t  b_ones_i,
  output dist_t dist_o
);

  dist_t a_val_s;
  dist_t b_val_s;

  // Binary value of each pair; 7 bits hold 99 without overflow.
  assign a_val_s = ({3'b000, a_tens_i} * 7'd10) + {3'b000, a_ones_i};
  assign b_val_s = ({3'b000, b_tens_i} * 7'd10) + {3'b000, b_ones_i};

  assign dist_o = (a_val_s >= b_val_s) ? (a_val_s - b_val_s) : (b_val_s - a_val_s);

endmodule

// File: rtl/hot_cold_game_ctrl.sv
// -----------------------------------------------------------------------------
// hot_cold_game_ctrl
// Game sequencer: latches a two-digit BCD target on stop_p, assembles keypad
// digits into two-digit guesses and scores each guess as correct / closer /
// farther relative to the previous guess.
//
// Optional feature: define HOT_COLD_GUESS_LIMIT_EN to end the game in LOSE once
// MAX_GUESSES wrong guesses have been evaluated. Without it, lose is tied 0.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   stop_p                : pulse, freeze target (only in IDLE)
//   seed_tens, seed_ones  : free-running counter digits latched as target
//   key_valid, key_code   : debounced key pulse and value (0-9, 4'hC clear)
//   show                  : display target instead of guess
//   disp_tens, disp_ones  : SSD digits (registered)
//   counting              : high in IDLE
//   correct/closer/farther: score of the last evaluated guess
//   lose                  : guess budget exhausted
//   attempts              : evaluated guesses, saturating at 15
// -----------------------------------------------------------------------------
module hot_cold_game_ctrl
  import hot_cold_pkg::*;
#(
  parameter int MAX_GUESSES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop_p,
  input  logic [3:0] seed_tens,
  input  logic [3:0] seed_ones,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       show,
  output logic [3:0] disp_tens,
  output logic [3:0] disp_ones,
  output logic       counting,
  output logic       correct,
  output logic       closer,
  output logic       farther,
  output logic       lose,
  output logic [3:0] attempts
);

`ifdef HOT_COLD_GUESS_LIMIT_EN
  localparam logic LIMIT_EN = 1'b1;
`else
  localparam logic LIMIT_EN = 1'b0;
`endif

  // Clamp to the counter range so the comparison stays 4 bits wide.
  localparam logic [3:0] GUESS_LIMIT = (MAX_GUESSES > 15) ? 4'd15 : MAX_GUESSES[3:0];

  state_t     state_q, state_d;
  bcd_t       tgt_t_q, tgt_t_d, tgt_o_q, tgt_o_d;
  bcd_t       g_t_q, g_t_d, g_o_q, g_o_d;
  dist_t      prev_q, prev_d;
  logic       first_q, first_d;
  logic       correct_q, correct_d;
  logic       closer_q, closer_d;
  logic       farther_q, farther_d;
  logic       lose_q, lose_d;
  logic [3:0] att_q, att_d;
  bcd_t       disp_t_q, disp_t_d, disp_o_q, disp_o_d;
  logic       counting_q, counting_d;

  dist_t      dist_s;
  logic       digit_s;
  logic       clear_s;

  assign digit_s = key_valid & is_digit(key_code);
  assign clear_s = key_valid & (key_code == KEY_CLEAR);

  bcd_dist u_dist (
    .a_tens_i (g_t_q),
    .a_ones_i (g_o_q),
    .b_tens_i (tgt_t_q),
    .b_ones_i (tgt_o_q),
    .dist_o   (dist_s)
  );

  // Next-state, scoring and display selection.
  always_comb begin
    state_d   = state_q;
    tgt_t_d   = tgt_t_q;
    tgt_o_d   = tgt_o_q;
    g_t_d     = g_t_q;
    g_o_d     = g_o_q;
    prev_d    = prev_q;
    first_d   = first_q;
    correct_d = correct_q;
    closer_d  = closer_q;
    farther_d = farther_q;
    lose_d    = lose_q;
    att_d     = att_q;

    case (state_q)
      IDLE: begin
        // Keys are ignored here, so stop_p wins over a same-cycle key.
        if (stop_p) begin
          tgt_t_d = seed_tens;
          tgt_o_d = seed_ones;
          state_d = ENTER_T;
        end else begin
          state_d = IDLE;
        end
      end
      ENTER_T, RESULT: begin
        // A digit here is always the tens digit of a fresh guess.
        if (digit_s) begin
          g_t_d   = key_code;
          g_o_d   = 4'd0;
          state_d = ENTER_O;
        end else if (clear_s) begin
          g_t_d   = 4'd0;
          g_o_d   = 4'd0;
          state_d = ENTER_T;
        end else begin
          state_d = state_q;
        end
      end
      ENTER_O: begin
        if (digit_s) begin
          g_o_d   = key_code;
          state_d = EVAL;
        end else if (clear_s) begin
          g_t_d   = 4'd0;
          g_o_d   = 4'd0;
          state_d = ENTER_T;
        end else begin
          state_d = ENTER_O;
        end
      end
      EVAL: begin
        correct_d = (dist_s == 7'd0);
        // The first guess has nothing to compare against.
        if (first_q) begin
          closer_d  = 1'b0;
          farther_d = 1'b0;
        end else begin
          closer_d  = (dist_s < prev_q);
          farther_d = (dist_s > prev_q);
        end
        prev_d  = dist_s;
        first_d = 1'b0;
        if (att_q == ATTEMPTS_MAX) begin
          att_d = att_q;
        end else begin
          att_d = att_q + 4'd1;
        end
        if (correct_d) begin
          state_d = WIN;
        end else if (LIMIT_EN && (att_d >= GUESS_LIMIT)) begin
          lose_d  = 1'b1;
          state_d = LOSE;
        end else begin
          state_d = RESULT;
        end
      end
      WIN:     state_d = WIN;
      LOSE:    state_d = LOSE;
      default: state_d = IDLE;
    endcase

    if (show) begin
      disp_t_d = tgt_t_d;
      disp_o_d = tgt_o_d;
    end else begin
      disp_t_d = g_t_d;
      disp_o_d = g_o_d;
    end
    counting_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tgt_t_q    <= 4'd0;
      tgt_o_q    <= 4'd0;
      g_t_q      <= 4'd0;
      g_o_q      <= 4'd0;
      prev_q     <= 7'd0;
      first_q    <= 1'b1;
      correct_q  <= 1'b0;
      closer_q   <= 1'b0;
      farther_q  <= 1'b0;
      lose_q     <= 1'b0;
      att_q      <= 4'd0;
      disp_t_q   <= 4'd0;
      disp_o_q   <= 4'd0;
      counting_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      tgt_t_q    <= tgt_t_d;
      tgt_o_q    <= tgt_o_d;
      g_t_q      <= g_t_d;
      g_o_q      <= g_o_d;
      prev_q     <= prev_d;
      first_q    <= first_d;
      correct_q  <= correct_d;
      closer_q   <= closer_d;
      farther_q  <= farther_d;
      lose_q     <= lose_d;
      att_q      <= att_d;
      disp_t_q   <= disp_t_d;
      disp_o_q   <= disp_o_d;
      counting_q <= counting_d;
    end
  end

  assign disp_tens = disp_t_q;
  assign disp_ones = disp_o_q;
  assign counting  = counting_q;
  assign correct   = correct_q;
  assign closer    = closer_q;
  assign farther   = farther_q;
  assign lose      = lose_q;
  assign attempts  = att_q;

endmodule

// File: tb/tb_hot_cold_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hot_cold_game_ctrl
// Directed game scenarios followed by randomized games. A reference model of
// the game rules predicts every clock; each evaluated guess is pushed into a
// scoreboard queue and a monitor pops it when the DUT's attempts count moves.
// -----------------------------------------------------------------------------
module tb_hot_cold_game_ctrl;

  localparam int TB_MAX = 2;
`ifdef HOT_COLD_GUESS_LIMIT_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, stop_p, key_valid, show;
  logic [3:0] seed_tens, seed_ones, key_code;
  logic [3:0] disp_tens, disp_ones, attempts;
  logic       counting, correct, closer, farther, lose;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit sh     = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hot_cold_game_ctrl #(.MAX_GUESSES(TB_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .stop_p    (stop_p),
    .seed_tens (seed_tens),
    .seed_ones (seed_ones),
    .key_valid (key_valid),
    .key_code  (key_code),
    .show      (show),
    .disp_tens (disp_tens),
    .disp_ones (disp_ones),
    .counting  (counting),
    .correct   (correct),
    .closer    (closer),
    .farther   (farther),
    .lose      (lose),
    .attempts  (attempts)
  );

  // ---------------- reference model (game rules) ----------------
  typedef enum {M_IDLE, M_TENS, M_ONES, M_EVAL, M_RES, M_OVER} mphase_t;
  typedef struct {
    int due;
    bit cor, clo, far, los;
    int att;
  } exp_t;

  mphase_t ph;
  int tgt, gt, go, prev, att, m_dt, m_do;
  bit first, m_cor, m_clo, m_far, m_lose, m_cnt;
  exp_t sbq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input int st, input int so,
                            input bit kv, input int kc, input bit shw);
    int d;
    exp_t e;
    bit dig, clr;
    dig = kv && (kc <= 9);
    clr = kv && (kc == 12);
    if (r) begin
      ph = M_IDLE; tgt = 0; gt = 0; go = 0; prev = 0; att = 0; first = 1'b1;
      m_cor = 0; m_clo = 0; m_far = 0; m_lose = 0;
    end else begin
      case (ph)
        M_IDLE: if (s) begin tgt = st * 10 + so; ph = M_TENS; end
        M_TENS, M_RES: begin
          if (dig) begin gt = kc; go = 0; ph = M_ONES; end
          else if (clr) begin gt = 0; go = 0; ph = M_TENS; end
        end
        M_ONES: begin
          if (dig) begin go = kc; ph = M_EVAL; end
          else if (clr) begin gt = 0; go = 0; ph = M_TENS; end
        end
        M_EVAL: begin
          d = (gt * 10 + go) - tgt;
          if (d < 0) d = -d;
          m_cor = (d == 0);
          m_clo = !first && (d < prev);
          m_far = !first && (d > prev);
          prev = d;
          first = 1'b0;
          att = (att < 15) ? att + 1 : 15;
          m_lose = LIM && !m_cor && (att >= TB_MAX);
          ph = (m_cor || m_lose) ? M_OVER : M_RES;
          e.due = cyc + 1; e.cor = m_cor; e.clo = m_clo; e.far = m_far;
          e.los = m_lose; e.att = att;
          sbq.push_back(e);
        end
        default: ;
      endcase
    end
    if (shw) begin m_dt = tgt / 10; m_do = tgt % 10; end
    else begin m_dt = gt; m_do = go; end
    m_cnt = (ph == M_IDLE);
  endtask

  task automatic check_all();
    chk("disp_tens", {28'd0, disp_tens}, m_dt);
    chk("disp_ones", {28'd0, disp_ones}, m_do);
    chk("counting",  {31'd0, counting},  {31'd0, m_cnt});
    chk("correct",   {31'd0, correct},   {31'd0, m_cor});
    chk("closer",    {31'd0, closer},    {31'd0, m_clo});
    chk("farther",   {31'd0, farther},   {31'd0, m_far});
    chk("lose",      {31'd0, lose},      {31'd0, m_lose});
    chk("attempts",  {28'd0, attempts},  att);
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic drive(input bit r, input bit s, input int st, input int so,
                       input bit kv, input int kc);
    rst = r; stop_p = s; seed_tens = 4'(st); seed_ones = 4'(so);
    key_valid = kv; key_code = 4'(kc); show = sh;
    model_step(r, s, st, so, kv, kc, sh);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 0);
  endtask
  task automatic key(input int k);
    drive(1'b0, 1'b0, 0, 0, 1'b1, k);
  endtask
  task automatic do_reset();
    sh = 1'b0;
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
  endtask
  task automatic start(input int t, input int o);
    drive(1'b0, 1'b1, t, o, 1'b0, 0);
  endtask
  task automatic guess(input int t, input int o);
    key(t); key(o); idle(2);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [3:0] last;
    exp_t e;
    last = 4'd0;
    forever begin
      @(negedge clk);
      #1;
      if (attempts !== last && attempts !== 4'd0) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_eval", {28'd0, attempts}, {28'd0, last});
        end else begin
          e = sbq.pop_front();
          chk("sb_cycle",    cyc, e.due);
          chk("sb_correct",  {31'd0, correct}, {31'd0, e.cor});
          chk("sb_closer",   {31'd0, closer},  {31'd0, e.clo});
          chk("sb_farther",  {31'd0, farther}, {31'd0, e.far});
          chk("sb_lose",     {31'd0, lose},    {31'd0, e.los});
          chk("sb_attempts", {28'd0, attempts}, e.att);
        end
      end
      last = attempts;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int nops, op, r;
    rst = 1'b1; stop_p = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    seed_tens = 4'd0; seed_ones = 4'd0; show = 1'b0;

    // Reset state
    do_reset();
    chk("rst_counting", {31'd0, counting}, 32'd1);
    chk("rst_attempts", {28'd0, attempts}, 32'd0);
    chk("rst_disp", {24'd0, disp_tens, disp_ones}, 32'd0);

    // 1: target 42, guess 42
    start(4, 2); key(4); key(2); idle(1);
    chk("t1_correct", {31'd0, correct}, 32'd1);
    chk("t1_attempts", {28'd0, attempts}, 32'd1);
    key(5); idle(1);

    // 2: target 50; 10, 30, 80; a key during EVAL is dropped
    do_reset(); start(5, 0);
    guess(1, 0);
    key(3); key(0); key(7); idle(1);
    chk("t2_closer", {31'd0, closer}, 32'd1);
    guess(8, 0);
    chk("t2_farther", {31'd0, farther}, 32'd1);

    // 3: equal distance, then win and ignored keys
    do_reset(); start(5, 0);
    guess(4, 0); guess(6, 0);
    chk("t3_flags", {30'd0, closer, farther}, 32'd0);
    guess(5, 0); key(1); key(12); idle(1);

    // 4: clear mid entry, then show target
    do_reset(); start(0, 7);
    key(3); key(12); key(0); key(7); idle(2);
    sh = 1'b1; idle(1);
    chk("t4_disp", {24'd0, disp_tens, disp_ones}, 32'h07);
    sh = 1'b0; idle(1);

    // 5: guess budget (only ends the game when the limit is built in)
    do_reset(); start(9, 9);
    guess(0, 0); guess(0, 1); guess(0, 2);
    do_reset();

    // 6: stop_p with a same-cycle key, then reset in ENTER_O
    drive(1'b0, 1'b1, 3, 3, 1'b1, 5);
    chk("t6_guess_dropped", {24'd0, disp_tens, disp_ones}, 32'd0);
    key(1);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0);
    chk("t6_rst_counting", {31'd0, counting}, 32'd1);

    // Randomized games
    for (int g = 0; g < 25; g++) begin
      do_reset();
      idle($urandom_range(0, 2));
      start($urandom_range(0, 9), $urandom_range(0, 9));
      nops = 24;
      for (int i = 0; i < nops; i++) begin
        op = $urandom_range(0, 9);
        if (op < 6) begin
          r = $urandom_range(0, 4);
          key((r == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
        end else if (op == 6) begin
          sh = ~sh; idle(1);
        end else if (op == 7) begin
          drive(1'b0, 1'b1, $urandom_range(0, 9), $urandom_range(0, 9), 1'b0, 0);
        end else begin
          idle($urandom_range(1, 2));
        end
      end
      idle(2);
    end

    idle(3);
    chk("sb_empty", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
